// File: rtl/adder_pkg.sv
// Shared constants, stage-register layout and configuration check for pipelined_adder.
// PIPELINED_ADDER_SUB_EN (see pipelined_adder.sv) adds a subtract mode carried in the sub field.
package adder_pkg;

  localparam int ADDER_DEF_WIDTH  = 16;
  localparam int ADDER_DEF_STAGES = 4;

  // Stage register at the default width; pipelined_adder declares the same layout at its own WIDTH.
  typedef struct packed {
    logic                       valid;
    logic [ADDER_DEF_WIDTH-1:0] s;
    logic [ADDER_DEF_WIDTH-1:0] a;
    logic [ADDER_DEF_WIDTH-1:0] b;
    logic                       c;
    logic                       cmsb;
    logic                       sub;
  } adder_stage_t;

  function automatic bit adder_cfg_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple-carry adder slice; also exposes the carry into its top bit
// so the final slice can report signed overflow.
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_top
);

  logic [W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = carry[W];
  assign c_top = carry[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: STAGES register-separated CHUNK-bit slices behind valid/ready.
// Define PIPELINED_ADDER_SUB_EN to add the sub port (a - b computed as a + ~b + 1).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_DEF_WIDTH,
  parameter int STAGES = ADDER_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!adder_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES <= WIDTH");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             cmsb;
    logic             sub;
  } stage_t;

  logic   advance;
  stage_t in_beat;

  // The whole pipeline moves in lockstep; a stalled output freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is folded in at the entry so every slice stays a plain adder.
  always_comb begin
    in_beat       = '0;
    in_beat.valid = in_valid;
    in_beat.a     = a;
`ifdef PIPELINED_ADDER_SUB_EN
    in_beat.b     = sub ? ~b : b;
    in_beat.c     = sub ? 1'b1 : cin;
    in_beat.sub   = sub;
`else
    in_beat.b     = b;
    in_beat.c     = cin;
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           stage_d;
    stage_t           stage_q;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_ctop;

    if (k == 0) begin : g_first
      assign src = in_beat;
    end else begin : g_next
      assign src = g_stage[k-1].stage_q;
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a     (src.a[k*CHUNK +: CHUNK]),
      .b     (src.b[k*CHUNK +: CHUNK]),
      .cin   (src.c),
      .sum   (chunk_sum),
      .cout  (chunk_cout),
      .c_top (chunk_ctop)
    );

    always_comb begin
      stage_d                     = src;
      stage_d.s[k*CHUNK +: CHUNK] = chunk_sum;
      stage_d.c                   = chunk_cout;
      if (k == STAGES - 1) begin
        stage_d.cmsb = chunk_ctop;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else if (advance) begin
        stage_q <= stage_d;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].stage_q.valid;
  assign sum       = g_stage[STAGES-1].stage_q.s;
  assign cout      = g_stage[STAGES-1].stage_q.c;
  assign overflow  = g_stage[STAGES-1].stage_q.cmsb ^ g_stage[STAGES-1].stage_q.c;

endmodule
